// File: rtl/cmd_wbmaster_wb8_pkg.sv
// Shared constants and state encoding for the
// byte-stream to Wishbone 8-bit bridge.
package cmd_wbmaster_wb8_pkg;

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;
  localparam logic [7:0] RSP_OK   = 8'hA5;
  localparam logic [7:0] RSP_ERR  = 8'hEE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LEN,
    S_WDATA,
    S_WB_WR,
    S_WB_RD,
    S_TX_DATA,
    S_TX_STATUS
  } state_t;

endpackage

// File: rtl/cmd_wbmaster_wb8.sv
// Command-stream driven Wishbone 8-bit initiator:
// parses opcode/address/length frames, runs bursts.
module cmd_wbmaster_wb8
  import cmd_wbmaster_wb8_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [7:0]  I_rx_data,
  input  logic        I_rx_valid,
  output logic        O_rx_ready,
  output logic [7:0]  O_tx_data,
  output logic        O_tx_valid,
  input  logic        I_tx_ready,
  output logic [31:0] ADR_O,
  output logic [7:0]  DAT_O,
  input  logic [7:0]  DAT_I,
  output logic        CYC_O,
  output logic        STB_O,
  output logic        WE_O,
  input  logic        ACK_I,
  output logic        O_busy
);

  localparam int unsigned TW =
    (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST =
    TW'(TIMEOUT_CYCLES - 1);

  state_t        r_state, w_state;
  logic          r_live;
  logic          r_wr, w_wr;
  logic [31:0]   r_adr, w_adr;
  logic [1:0]    r_idx, w_idx;
  logic [8:0]    r_cnt, w_cnt;
  logic [7:0]    r_dat, w_dat;
  logic [7:0]    r_txd, w_txd;
  logic [TW-1:0] r_tmo, w_tmo;

  logic w_rx_fire;
  logic w_tx_fire;
  logic w_inbus;

  // r_live keeps rx_ready low until the first edge after reset
  assign O_rx_ready = r_live && (r_state inside
    {S_IDLE, S_ADDR, S_LEN, S_WDATA});
  assign O_tx_valid = r_state inside {S_TX_DATA, S_TX_STATUS};
  assign w_inbus    = r_state inside {S_WB_WR, S_WB_RD};
  assign CYC_O      = w_inbus;
  assign STB_O      = w_inbus;
  assign WE_O       = (r_state == S_WB_WR);
  assign ADR_O      = r_adr;
  assign DAT_O      = r_dat;
  assign O_tx_data  = r_txd;
  assign O_busy     = (r_state != S_IDLE);

  assign w_rx_fire = I_rx_valid && O_rx_ready;
  assign w_tx_fire = O_tx_valid && I_tx_ready;

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_state <= S_IDLE;
      r_live  <= 1'b0;
      r_wr    <= 1'b0;
      r_adr   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_dat   <= '0;
      r_txd   <= '0;
      r_tmo   <= '0;
    end else begin
      r_state <= w_state;
      r_live  <= 1'b1;
      r_wr    <= w_wr;
      r_adr   <= w_adr;
      r_idx   <= w_idx;
      r_cnt   <= w_cnt;
      r_dat   <= w_dat;
      r_txd   <= w_txd;
      r_tmo   <= w_tmo;
    end
  end

  always_comb begin
    w_state = r_state;
    w_wr    = r_wr;
    w_adr   = r_adr;
    w_idx   = r_idx;
    w_cnt   = r_cnt;
    w_dat   = r_dat;
    w_txd   = r_txd;
    w_tmo   = r_tmo;
    unique case (r_state)
      S_IDLE: if (w_rx_fire) begin
        if (I_rx_data == OP_WRITE ||
            I_rx_data == OP_READ) begin
          w_wr    = (I_rx_data == OP_WRITE);
          w_idx   = '0;
          w_state = S_ADDR;
        end else begin
          w_txd   = RSP_ERR;
          w_state = S_TX_STATUS;
        end
      end
      S_ADDR: if (w_rx_fire) begin
        w_adr = {I_rx_data, r_adr[31:8]};
        w_idx = r_idx + 2'd1;
        if (r_idx == 2'd3) w_state = S_LEN;
      end
      S_LEN: if (w_rx_fire) begin
        w_cnt   = (I_rx_data == 8'd0) ? 9'd256
                                      : {1'b0, I_rx_data};
        w_state = r_wr ? S_WDATA : S_WB_RD;
      end
      S_WDATA: if (w_rx_fire) begin
        w_dat   = I_rx_data;
        w_state = S_WB_WR;
      end
      S_WB_WR, S_WB_RD: begin
        if (ACK_I) begin
          w_adr = r_adr + 32'd1;
          w_cnt = r_cnt - 9'd1;
          w_tmo = '0;
          if (r_state == S_WB_RD) begin
            w_txd   = DAT_I;
            w_state = S_TX_DATA;
          end else if (r_cnt == 9'd1) begin
            w_txd   = RSP_OK;
            w_state = S_TX_STATUS;
          end else begin
            w_state = S_WDATA;
          end
        end else if (r_tmo == TMO_LAST) begin
          w_tmo   = '0;
          w_txd   = RSP_ERR;
          w_state = S_TX_STATUS;
        end else begin
          w_tmo = r_tmo + 1'b1;
        end
      end
      S_TX_DATA: if (w_tx_fire) begin
        w_state = (r_cnt == 9'd0) ? S_IDLE : S_WB_RD;
      end
      S_TX_STATUS: if (w_tx_fire) begin
        w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

endmodule
